// File: rtl/ppg_line_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ppg_line_seq_if                                              |
// | Description : Control/status bundle between the frame sequencer and its   |
// |               register plane and DG412 driver arm chain.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface ppg_line_seq_if #(
    parameter int CW = 16
);
    logic          start;
    logic          abort;
    logic          cfg_v3mode;
    logic [CW-1:0] cfg_lines;
    logic [CW-1:0] cfg_period;
    logic [CW-1:0] cfg_h_delay;
    logic          armed_all;

    logic          arm;
    logic          trig_l;
    logic          trig_h;
    logic          v3mode;
    logic          busy;
    logic [CW-1:0] line_idx;
    logic          done;
    logic          aborted;
    logic          err_arm;

    modport master (
        output start, abort, cfg_v3mode, cfg_lines, cfg_period, cfg_h_delay, armed_all,
        input  arm, trig_l, trig_h, v3mode, busy, line_idx, done, aborted, err_arm
    );

    modport slave (
        input  start, abort, cfg_v3mode, cfg_lines, cfg_period, cfg_h_delay, armed_all,
        output arm, trig_l, trig_h, v3mode, busy, line_idx, done, aborted, err_arm
    );
endinterface
`default_nettype wire

// File: rtl/ppg_line_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ppg_line_seq                                                 |
// | Description : Frame sequencer: arms the DG412 drivers, then issues the     |
// |               programmed number of trig_l (and V3 trig_h) line pulses.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ppg_line_seq #(
    parameter int CW          = 16,
    parameter int ARM_TIMEOUT = 1023,
    parameter int MIN_PERIOD  = 2
) (
    input  wire logic     clk_fast,
    input  wire logic     rst,
    ppg_line_seq_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ARM  = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [CW-1:0] c_MIN_PERIOD = CW'(MIN_PERIOD);
    localparam logic [CW-1:0] c_TMO_LAST   = CW'(ARM_TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_lines;
    logic [CW-1:0] r_period;
    logic [CW-1:0] r_h_delay;
    logic          r_hv;
    logic [CW-1:0] r_pc;
    logic [CW-1:0] r_line;
    logic [CW-1:0] r_tmo;
    logic          r_arm;
    logic          r_busy;
    logic          r_trig_l;
    logic          r_trig_h;
    logic          r_v3mode;
    logic          r_done;
    logic          r_aborted;
    logic          r_err;

    logic [CW-1:0] w_period_clamped;
    logic          w_hv;
    logic          w_line_end;
    logic          w_last_line;
    logic [CW-1:0] w_pc_next;
    logic          w_stop;

    // trig_h is only meaningful when it lands strictly inside the line period
    assign w_period_clamped = (bus.cfg_period < c_MIN_PERIOD) ? c_MIN_PERIOD : bus.cfg_period;
    assign w_hv             = bus.cfg_v3mode && (bus.cfg_h_delay != '0)
                              && (bus.cfg_h_delay < w_period_clamped);
    assign w_line_end       = (r_pc == r_period - 1'b1);
    assign w_last_line      = (r_line == r_lines - 1'b1);
    assign w_pc_next        = w_line_end ? '0 : r_pc + 1'b1;
    // a disarmed driver chain invalidates the frame just like an abort
    assign w_stop           = bus.abort || !bus.armed_all;

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_lines   <= '0;
            r_period  <= '0;
            r_h_delay <= '0;
            r_hv      <= 1'b0;
            r_pc      <= '0;
            r_line    <= '0;
            r_tmo     <= '0;
            r_arm     <= 1'b0;
            r_busy    <= 1'b0;
            r_trig_l  <= 1'b0;
            r_trig_h  <= 1'b0;
            r_v3mode  <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_trig_l  <= 1'b0;
            r_trig_h  <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_lines   <= bus.cfg_lines;
                        r_period  <= w_period_clamped;
                        r_h_delay <= bus.cfg_h_delay;
                        r_hv      <= w_hv;
                        r_v3mode  <= bus.cfg_v3mode;
                        if (bus.cfg_lines == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= c_ST_ARM;
                            r_arm   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_tmo   <= '0;
                        end
                    end
                end
                c_ST_ARM: begin
                    if (bus.abort) begin
                        r_state   <= c_ST_IDLE;
                        r_arm     <= 1'b0;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (bus.armed_all) begin
                        r_state  <= c_ST_RUN;
                        r_pc     <= '0;
                        r_line   <= '0;
                        r_trig_l <= 1'b1;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_arm   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_ST_RUN: begin
                    if (w_stop) begin
                        r_state   <= c_ST_IDLE;
                        r_arm     <= 1'b0;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (w_line_end && w_last_line) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        // triggers are registered from the next pc so they align with it
                        r_pc     <= w_pc_next;
                        r_trig_l <= (w_pc_next == '0);
                        r_trig_h <= r_hv && (w_pc_next == r_h_delay);
                        if (w_line_end) begin
                            r_line <= r_line + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_arm   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.arm      = r_arm;
    assign bus.trig_l   = r_trig_l;
    assign bus.trig_h   = r_trig_h;
    assign bus.v3mode   = r_v3mode;
    assign bus.busy     = r_busy;
    assign bus.line_idx = r_line;
    assign bus.done     = r_done;
    assign bus.aborted  = r_aborted;
    assign bus.err_arm  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ppg_line_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ppg_line_seq                                              |
// | Description : Self-checking bench for ppg_line_seq with a frame-time model.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ppg_line_seq;
    localparam int CW          = 16;
    localparam int ARM_TIMEOUT = 1023;
    localparam int MIN_PERIOD  = 2;

    logic clk_fast = 1'b0;
    logic rst      = 1'b1;

    ppg_line_seq_if #(.CW(CW)) bus ();

    ppg_line_seq #(
        .CW          (CW),
        .ARM_TIMEOUT (ARM_TIMEOUT),
        .MIN_PERIOD  (MIN_PERIOD)
    ) dut (
        .clk_fast (clk_fast),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk_fast = ~clk_fast;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int am_mode = 1;
    int arm_cnt = 0;

    // model state: frame time since the first trig_l, arm-wait time since arm rose
    int     m_phase = 0;
    longint m_t, m_w, m_lines, m_period, m_hd;
    bit     m_hv;
    logic   e_arm = 0, e_tl = 0, e_th = 0, e_v3 = 0, e_busy = 0, e_done = 0, e_abt = 0, e_err = 0;
    logic [CW-1:0] e_line = '0;

    int tl_k[$], th_k[$], dn_k[$], ab_k[$], er_k[$];
    int ab_line;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [23:0] dut_vec();
        return {bus.arm, bus.trig_l, bus.trig_h, bus.v3mode, bus.busy,
                bus.done, bus.aborted, bus.err_arm, bus.line_idx};
    endfunction

    task automatic model_step();
        e_tl = 0; e_th = 0; e_done = 0; e_abt = 0; e_err = 0;
        if (rst) begin
            m_phase = 0; e_arm = 0; e_v3 = 0; e_busy = 0; e_line = '0;
        end else if (m_phase == 0) begin
            if (bus.start && !bus.abort) begin
                m_lines  = bus.cfg_lines;
                m_period = (bus.cfg_period < MIN_PERIOD) ? MIN_PERIOD : bus.cfg_period;
                m_hd     = bus.cfg_h_delay;
                m_hv     = bus.cfg_v3mode && m_hd > 0 && m_hd < m_period;
                e_v3     = bus.cfg_v3mode;
                if (m_lines == 0) e_done = 1;
                else begin m_phase = 1; m_w = 0; e_arm = 1; e_busy = 1; end
            end
        end else if (m_phase == 1) begin
            m_w++;
            if (bus.abort) begin m_phase = 0; e_arm = 0; e_busy = 0; e_abt = 1; end
            else if (bus.armed_all) begin m_phase = 2; m_t = 0; e_line = '0; e_tl = 1; end
            else if (m_w == ARM_TIMEOUT) begin m_phase = 0; e_arm = 0; e_busy = 0; e_err = 1; end
        end else if (m_phase == 2) begin
            if (bus.abort || !bus.armed_all) begin
                m_phase = 0; e_arm = 0; e_busy = 0; e_abt = 1;
            end else begin
                m_t++;
                if (m_t == m_lines * m_period) begin
                    m_phase = 3; e_done = 1;
                end else begin
                    e_line = CW'(m_t / m_period);
                    e_tl   = (m_t % m_period) == 0;
                    e_th   = m_hv && ((m_t % m_period) == m_hd);
                end
            end
        end else begin
            m_phase = 0; e_arm = 0; e_busy = 0;
        end
    endtask

    // one clock: model advances on the edge, DUT compared mid-cycle, driver-arm emulation
    task automatic tick();
        @(posedge clk_fast);
        model_step();
        @(negedge clk_fast);
        cyc++;
        chk($sformatf("model_cyc%0d", cyc), dut_vec(),
            {e_arm, e_tl, e_th, e_v3, e_busy, e_done, e_abt, e_err, e_line});
        if (bus.arm) arm_cnt++; else arm_cnt = 0;
        bus.armed_all = (am_mode == 1) && (arm_cnt >= 4);
    endtask

    task automatic start_frame(input bit v3, input int lines, input int period, input int hd);
        bus.cfg_v3mode  = v3;
        bus.cfg_lines   = CW'(lines);
        bus.cfg_period  = CW'(period);
        bus.cfg_h_delay = CW'(hd);
        bus.start = 1'b1;
        tick();
        bus.start       = 1'b0;
        bus.cfg_v3mode  = 1'($urandom);
        bus.cfg_lines   = CW'($urandom);
        bus.cfg_period  = CW'($urandom);
        bus.cfg_h_delay = CW'($urandom);
    endtask

    // k=0 is the current mid-cycle point; records pulse offsets relative to it
    task automatic watch(input int n, input int start_at, input int abort_at, input int disarm_at);
        tl_k.delete(); th_k.delete(); dn_k.delete(); ab_k.delete(); er_k.delete();
        ab_line = -1;
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            if (bus.trig_l)  tl_k.push_back(k);
            if (bus.trig_h)  th_k.push_back(k);
            if (bus.done)    dn_k.push_back(k);
            if (bus.err_arm) er_k.push_back(k);
            if (bus.aborted) begin ab_k.push_back(k); ab_line = int'(bus.line_idx); end
            bus.start = (k == start_at);
            bus.abort = (k == abort_at);
            if (k == disarm_at) begin am_mode = 0; bus.armed_all = 1'b0; end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.armed_all = 0; bus.cfg_v3mode = 0;
        bus.cfg_lines = '0; bus.cfg_period = '0; bus.cfg_h_delay = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_outputs", dut_vec(), 0);

        // V2 frame: arm at k=0, armed_all 4 cycles later
        start_frame(0, 3, 100, 0);
        watch(310, -1, -1, -1);
        chk("v2_ntrig", tl_k.size(), 3);
        chk("v2_trig0", qat(tl_k, 0), 4);
        chk("v2_trig1", qat(tl_k, 1), 104);
        chk("v2_trig2", qat(tl_k, 2), 204);
        chk("v2_no_trig_h", th_k.size(), 0);
        chk("v2_done", qat(dn_k, 0), 304);
        chk("v2_idle_after", {bus.arm, bus.busy}, 0);

        // arm timeout
        am_mode = 0;
        start_frame(0, 5, 10, 0);
        watch(1030, -1, -1, -1);
        chk("tmo_err_at", qat(er_k, 0), 1023);
        chk("tmo_no_trig", tl_k.size(), 0);
        chk("tmo_idle_after", {bus.arm, bus.busy}, 0);
        am_mode = 1;

        // h_delay equal to period disables trig_h
        start_frame(1, 2, 300, 300);
        watch(610, -1, -1, -1);
        chk("clamp_ntrig", tl_k.size(), 2);
        chk("clamp_no_trig_h", th_k.size(), 0);
        chk("clamp_done", qat(dn_k, 0), 604);

        // V3 frame, cut short by abort after the second trig_h
        start_frame(1, 2, 40320, 20160);
        watch(60490, -1, 60488, -1);
        chk("v3_trig1", qat(tl_k, 1), 40324);
        chk("v3_trig_h0", qat(th_k, 0), 20164);
        chk("v3_trig_h1", qat(th_k, 1), 60484);
        chk("v3_v3mode_abort", qat(ab_k, 0), 60489);

        // abort at line 4, pc 17
        start_frame(0, 10, 50, 0);
        watch(260, -1, 4 + 217, -1);
        chk("abort_at", qat(ab_k, 0), 222);
        chk("abort_line", ab_line, 4);
        chk("abort_ntrig", tl_k.size(), 5);
        chk("abort_no_done", dn_k.size(), 0);
        chk("abort_line_hold", bus.line_idx, 4);

        // period 0 clamps to MIN_PERIOD
        start_frame(0, 4, 0, 0);
        watch(20, -1, -1, -1);
        chk("p0_trig3", qat(tl_k, 3), 10);
        chk("p0_done", qat(dn_k, 0), 12);

        // lines 0, then start+abort together in IDLE
        start_frame(0, 0, 7, 0);
        chk("lines0_done", {bus.done, bus.arm, bus.busy}, 3'b100);
        bus.start = 1; bus.abort = 1;
        tick();
        bus.start = 0; bus.abort = 0;
        watch(8, -1, -1, -1);
        chk("start_abort_idle", {bus.busy, bus.arm}, 0);

        // start while busy ignored (cfg scrambled during the frame)
        start_frame(0, 3, 10, 0);
        watch(50, 10, -1, -1);
        chk("busy_start_ntrig", tl_k.size(), 3);
        chk("busy_start_done", qat(dn_k, 0), 34);
        chk("busy_start_idle", bus.busy, 0);

        // abort coinciding with the last line end beats done
        start_frame(0, 2, 10, 0);
        watch(30, -1, 23, -1);
        chk("last_abort_at", qat(ab_k, 0), 24);
        chk("last_abort_no_done", dn_k.size(), 0);

        // driver disarm in RUN
        start_frame(0, 5, 20, 0);
        watch(60, -1, -1, 30);
        chk("disarm_abort_at", qat(ab_k, 0), 31);
        chk("disarm_no_done", dn_k.size(), 0);
        am_mode = 1;

        // reset mid-frame, then a normal frame
        start_frame(0, 5, 20, 0);
        watch(30, -1, -1, -1);
        rst = 1'b1;
        tick();
        chk("midreset_outputs", dut_vec(), 0);
        rst = 1'b0;
        tick();
        start_frame(0, 1, 5, 0);
        watch(12, -1, -1, -1);
        chk("post_reset_trig", qat(tl_k, 0), 4);
        chk("post_reset_done", qat(dn_k, 0), 9);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ppg_line_seq.md
Name: ppg_line_seq

Overview:
- Frame-level sequencer for the vertical-clock pulse pattern generator (PPG) and its DG412 deadtime drivers, running in the clk_fast domain.
- On a start command it raises arm to the DG412 drivers and waits for all of them to report armed.
- It then issues a programmed number of line triggers: trig_l every line, plus a delayed trig_h per line in V3 mode.
- It reports completion, abort and error status to the register/control plane.

Parameters:
- CW, 16, width of line-count, period and delay counters.
- ARM_TIMEOUT, 1023, clk_fast cycles to wait for armed_all before raising err_arm.
- MIN_PERIOD, 2, minimum line period in cycles; smaller cfg_period values are clamped up to this.

Ports:
- clk_fast  in  1  PPG fast clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  1-cycle frame start request; accepted only in IDLE.
- abort  in  1  stop request; level or pulse.
- cfg_v3mode  in  1  enable trig_h generation for this frame.
- cfg_lines  in  CW  number of lines to trigger.
- cfg_period  in  CW  clk_fast cycles between consecutive trig_l pulses.
- cfg_h_delay  in  CW  cycles from trig_l to trig_h within a line (V3 only).
- armed_all  in  1  AND of all DG412 driver armed flags.
- arm  out  1  arm request to the DG412 drivers.
- trig_l  out  1  1-cycle line trigger to the PPG.
- trig_h  out  1  1-cycle high-phase trigger to the PPG.
- v3mode  out  1  latched cfg_v3mode, held steady for the whole frame.
- busy  out  1  high in any state other than IDLE.
- line_idx  out  CW  index of the current line; 0-based.
- done  out  1  1-cycle pulse when the frame completes normally.
- aborted  out  1  1-cycle pulse when the frame stops on abort or disarm.
- err_arm  out  1  1-cycle pulse when the arm wait times out.

Behaviour:
- Reset: every output is 0; state IDLE; counters 0. This also applies to a reset asserted mid-frame, which must not produce a done or aborted pulse.
- State IDLE:
  - start=1 and abort=0: latch all cfg_* inputs (later cfg changes are ignored until the next start). Clamp period to max(cfg_period, MIN_PERIOD). Set hv = cfg_v3mode and 0 < cfg_h_delay < period.
  - If cfg_lines==0: pulse done on the next cycle and stay in IDLE; arm never rises.
  - Otherwise go to ARM_WAIT with arm=1 and busy=1 from the next cycle.
  - start and abort together in IDLE: start is ignored.
- State ARM_WAIT:
  - A timeout counter counts cycles.
  - armed_all=1: go to RUN; trig_l is asserted in the first RUN cycle with line_idx=0 and pc=0.
  - Counter reaches ARM_TIMEOUT with no armed_all: err_arm pulse, arm=0, go to IDLE.
- State RUN:
  - pc is the period counter. trig_l=1 exactly when pc==0.
  - trig_h=1 exactly when hv and pc==h_delay.
  - At pc==period-1:
    - If line_idx==lines-1: go to DONE.
    - Otherwise pc wraps to 0 and line_idx increments.
  - Trigger spacing is exactly `period` cycles. The last line is given its full period before DONE.
- State DONE: done=1 for one cycle, arm=0, busy=0 on the following cycle; return to IDLE.
- Abort:
  - abort=1 in ARM_WAIT or RUN: next cycle is IDLE with trig_l=trig_h=0, arm=0 and an aborted pulse. line_idx holds its last value.
  - A trigger pulse is never truncated because pulses are 1 cycle long.
- Disarm: armed_all falling in RUN is treated as an abort (aborted pulse), since driver outputs are no longer guaranteed.
- Simultaneous events: abort takes priority over done at pc==period-1 of the last line. The result is an aborted pulse and no done.
- Counter width: pc, line_idx and the timeout counter are CW bits. lines up to 2^CW-1 must work without wrap aliasing.
- Output timing: all outputs are registered with no combinational paths from inputs.

Test Plan:
- V2 frame: cfg_lines=3, period=100, v3mode=0, armed_all tied to arm after 4 cycles.
  - trig_l fires at relative cycles 0, 100, 200; trig_h never fires.
  - done fires 300 cycles after the first trig_l; arm and busy then drop.
- V3 frame: lines=2, period=40320, h_delay=40321 clamps hv=0, so no trig_h. Repeat with h_delay=20160: trig_h fires at 20160 and 60480 cycles after the first trig_l.
- Arm timeout: armed_all held 0 with ARM_TIMEOUT=1023.
  - err_arm pulses 1023 cycles after arm rises; then arm=0, busy=0.
  - No trig_l is ever issued.
- Abort mid-frame: lines=10, period=50, abort asserted at line_idx=4, pc=17.
  - Next cycle: arm=0, an aborted pulse, and no further trig_l.
  - line_idx stays 4 and done never fires.
- Edge cases:
  - period=0 clamps to 2: triggers are spaced 2 cycles apart.
  - lines=0: done fires one cycle after start and arm never rises.
  - start while busy is ignored.
  - cfg change during RUN has no effect.
  - armed_all dropping mid-RUN produces an aborted pulse.
- Reset mid-frame: rst asserted during RUN. All outputs are 0 on the next cycle with no done or aborted pulse; a following start works normally.
